// File: rtl/rsa_decoder_if.sv
// Handshake bundle for rsa_decoder: ciphertext/key input side, plaintext output side,
// and debug taps exposing the controller and exponentiator FSM states.
interface rsa_decoder_if #(parameter int k = 192) ();
    // in_*: a word moves when in_valid && in_ready at a rising clk edge; out_*: a result
    // moves when out_valid && out_ready. Valid never waits on ready, and a raised valid
    // holds its payload stable until the transfer completes.
    logic         in_valid;
    logic         in_ready;
    logic [k-1:0] in_data;
    logic [k-1:0] d_key;
    logic [k-1:0] e_key;
    logic         out_valid;
    logic         out_ready;
    logic [k-1:0] out_data;
    logic         out_err;
    logic         busy;
    logic [2:0]   dbg_state;
    logic [2:0]   dbg_exp_state;

    modport master (
        output in_valid, in_data, d_key, e_key, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy, dbg_state, dbg_exp_state
    );

    modport slave (
        input  in_valid, in_data, d_key, e_key, out_ready,
        output in_ready, out_valid, out_data, out_err, busy, dbg_state, dbg_exp_state
    );
endinterface

// File: rtl/rsa_decoder.sv
// RSA decrypt front-end (plaintext = c^d mod m) around a radix-2 Montgomery mod_exp.
// Define RSA_DECODER_FAULT_CHECK_EN to re-encrypt each result with e and flag mismatches.
module rsa_mod_exp #(
    parameter int           k      = 192,
    parameter int           logk   = 8,
    parameter logic [k-1:0] m      = '0,
    parameter logic [k-1:0] exp_2k = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [k-1:0] x,
    input  logic [k-1:0] y,
    output logic [k-1:0] z,
    output logic         done,
    output logic [2:0]   dbg_state
);
    typedef enum logic [2:0] {ME_IDLE, ME_MUL, ME_FIN, ME_SCAN, ME_DONE} me_state_t;
    typedef enum logic [2:0] {P_TOMONT, P_ONE, P_SQ, P_MX, P_FROM} phase_t;

    me_state_t    state, state_nx;
    phase_t       phase, ld_phase;
    logic [k-1:0] ma, mb, ex, xm, acc, ld_a, ld_b, res;
    logic [k+1:0] t, sum, sum_m, red;
    logic [logk-1:0] i, ecnt;
    logic         lead, ld;

    // One Montgomery step: t = (t + a_i*b + q*m) / 2, with t kept below 2m.
    assign sum   = t + (ma[0] ? {2'b00, mb} : '0);
    assign sum_m = sum[0] ? sum + {2'b00, m} : sum;
    assign red   = (t >= {2'b00, m}) ? t - {2'b00, m} : t;
    assign res   = red[k-1:0];

    assign done      = (state == ME_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ME_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        ld_a     = acc;
        ld_b     = acc;
        ld_phase = P_SQ;
        case (state)
            ME_IDLE: if (start) begin
                state_nx = ME_MUL; ld = 1'b1; ld_a = y; ld_b = exp_2k; ld_phase = P_TOMONT;
            end
            ME_MUL: if (i == logk'(k - 1)) state_nx = ME_FIN;
            ME_FIN: case (phase)
                P_TOMONT: begin
                    state_nx = ME_MUL; ld = 1'b1; ld_a = k'(1); ld_b = exp_2k; ld_phase = P_ONE;
                end
                P_SQ: if (ex[k-1]) begin
                    state_nx = ME_MUL; ld = 1'b1; ld_a = res; ld_b = xm; ld_phase = P_MX;
                end else begin
                    state_nx = ME_SCAN;
                end
                P_FROM:  state_nx = ME_DONE;
                default: state_nx = ME_SCAN;
            endcase
            ME_SCAN: if (ecnt == '0) begin
                state_nx = ME_MUL; ld = 1'b1; ld_a = acc; ld_b = k'(1); ld_phase = P_FROM;
            end else if (!(lead && !ex[k-1])) begin
                state_nx = ME_MUL; ld = 1'b1; ld_phase = P_SQ;
            end
            ME_DONE: if (!start) state_nx = ME_IDLE;
            default: state_nx = ME_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= P_TOMONT; ma <= '0; mb <= '0; t <= '0; i <= '0;
            ex <= '0; ecnt <= '0; lead <= 1'b0; xm <= '0; acc <= '0; z <= '0;
        end else begin
            case (state)
                ME_IDLE: if (start) begin
                    ex <= x; ecnt <= logk'(k); lead <= 1'b1;
                end
                ME_MUL: begin
                    t <= sum_m >> 1; ma <= ma >> 1; i <= i + logk'(1);
                end
                ME_FIN: case (phase)
                    P_TOMONT: xm <= res;
                    P_ONE:    acc <= res;
                    P_SQ: begin
                        acc <= res;
                        if (!ex[k-1]) begin ex <= ex << 1; ecnt <= ecnt - logk'(1); end
                    end
                    P_MX: begin
                        acc <= res; ex <= ex << 1; ecnt <= ecnt - logk'(1);
                    end
                    default: z <= res;
                endcase
                ME_SCAN: if (ecnt != '0) begin
                    // Leading zero exponent bits are skipped rather than squared.
                    if (lead && !ex[k-1]) begin ex <= ex << 1; ecnt <= ecnt - logk'(1); end
                    else                  lead <= 1'b0;
                end
                default: ;
            endcase
            if (ld) begin
                ma <= ld_a; mb <= ld_b; t <= '0; i <= '0; phase <= ld_phase;
            end
        end
    end
endmodule

module rsa_decoder #(
    parameter int           k      = 192,
    parameter int           logk   = 8,
    parameter logic [k-1:0] m      = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff,
    parameter logic [k-1:0] exp_2k = 192'h000000000000000100000000000000020000000000000001
) (
    input logic         clk,
    input logic         rst_n,
    rsa_decoder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RANGE = 3'd1, S_EXP_RUN = 3'd2, S_EXP_REL = 3'd3, S_OUT = 3'd4
`ifdef RSA_DECODER_FAULT_CHECK_EN
        , S_CHK_RUN = 3'd5, S_CHK_REL = 3'd6, S_CMP = 3'd7
`endif
    } state_t;

    state_t       state, state_nx;
    logic [k-1:0] c_q, d_q, res_q, exp_x, exp_y, exp_z;
    logic         err_q, exp_start, exp_done;
    logic [2:0]   exp_state;
`ifdef RSA_DECODER_FAULT_CHECK_EN
    logic [k-1:0] e_q, chk_q;
`else
    logic         unused_e_key;
    assign unused_e_key = ^bus.e_key;
`endif

    assign bus.in_ready      = (state == S_IDLE);
    assign bus.out_valid     = (state == S_OUT);
    assign bus.busy          = (state != S_IDLE);
    assign bus.out_data      = res_q;
    assign bus.out_err       = err_q;
    assign bus.dbg_state     = state;
    assign bus.dbg_exp_state = exp_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        exp_start = 1'b0;
        exp_x     = d_q;
        exp_y     = c_q;
        case (state)
            S_IDLE:    if (bus.in_valid) state_nx = S_RANGE;
            S_RANGE:   state_nx = (c_q >= m) ? S_OUT : S_EXP_RUN;
            S_EXP_RUN: begin
                exp_start = 1'b1;
                if (exp_done) state_nx = S_EXP_REL;
            end
`ifdef RSA_DECODER_FAULT_CHECK_EN
            S_EXP_REL: state_nx = S_CHK_RUN;
            S_CHK_RUN: begin
                exp_start = 1'b1; exp_x = e_q; exp_y = res_q;
                if (exp_done) state_nx = S_CHK_REL;
            end
            S_CHK_REL: begin
                exp_x = e_q; exp_y = res_q; state_nx = S_CMP;
            end
            S_CMP:     state_nx = S_OUT;
`else
            S_EXP_REL: state_nx = S_OUT;
`endif
            S_OUT:     if (bus.out_ready) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0; d_q <= '0; res_q <= '0; err_q <= 1'b0;
`ifdef RSA_DECODER_FAULT_CHECK_EN
            e_q <= '0; chk_q <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    c_q <= bus.in_data; d_q <= bus.d_key; err_q <= 1'b0;
`ifdef RSA_DECODER_FAULT_CHECK_EN
                    e_q <= bus.e_key;
`endif
                end
                S_RANGE: if (c_q >= m) begin
                    res_q <= '0; err_q <= 1'b1;
                end
                S_EXP_RUN: if (exp_done) res_q <= exp_z;
`ifdef RSA_DECODER_FAULT_CHECK_EN
                S_CHK_RUN: if (exp_done) chk_q <= exp_z;
                S_CMP:     err_q <= (chk_q != c_q);
`endif
                default: ;
            endcase
        end
    end

    rsa_mod_exp #(.k(k), .logk(logk), .m(m), .exp_2k(exp_2k)) u_mod_exp (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (exp_start),
        .x         (exp_x),
        .y         (exp_y),
        .z         (exp_z),
        .done      (exp_done),
        .dbg_state (exp_state)
    );
endmodule

// File: tb/tb_rsa_decoder.sv
// Directed-vector bench for rsa_decoder: driver pushes expected {err,data}, monitor pops on output.
module tb_rsa_decoder;
    localparam int K = 192;
    localparam logic [K-1:0] M  = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
    localparam logic [K-1:0] R2 = 192'h000000000000000100000000000000020000000000000001;

    logic clk, rst_n;
    int   checks, errors, start_cnt;
    logic [K:0] exp_q[$];
    logic [K:0] mon_exp;

    rsa_decoder_if #(.k(K)) bus ();

    rsa_decoder #(.k(K), .logk(8), .m(M), .exp_2k(R2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) if (dut.exp_start) start_cnt <= start_cnt + 1;

    task automatic check(input string name, input logic [K:0] act, input logic [K:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [K:0] okv(input logic [K-1:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [K:0] errv(input logic [K-1:0] v);
        return {1'b1, v};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            check("busy_during_out", bus.busy, 1);
            check("in_ready_during_out", bus.in_ready, 0);
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out actual=%0h required=none", bus.out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_exp[K-1:0]);
                    check("out_err", bus.out_err, mon_exp[K]);
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [K-1:0] c, input logic [K-1:0] d, input logic [K-1:0] e,
                        input bit push, input logic [K:0] req);
        int n;
        if (push) exp_q.push_back(req);
        bus.in_data  = c;
        bus.d_key    = d;
        bus.e_key    = e;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        check("busy_after_accept", bus.busy, 1);
        check("in_ready_after_accept", bus.in_ready, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, s0;
        checks = 0; errors = 0; start_cnt = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.d_key = '0; bus.e_key = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_err", bus.out_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(K'(3), K'(2), K'(0), 1'b1, okv(K'(9)));
        bus.in_valid = 1'b0;
        drain();

        // back-to-back with in_valid held between words
        send(K'(5), K'(1), K'(0), 1'b1, okv(K'(5)));
        send(K'(0), K'(7), K'(0), 1'b1, okv(K'(0)));
        send(K'(1), K'(16'hFFFF), K'(0), 1'b1, okv(K'(1)));
        send(M - K'(1), K'(1), K'(0), 1'b1, okv(M - K'(1)));
        send(M - K'(1), K'(2), K'(0), 1'b1, okv(K'(1)));
        send(K'(5), K'(0), K'(0), 1'b1, okv(K'(1)));
        bus.in_valid = 1'b0;
        drain();

        // range reject: result two cycles after accept, exponentiator untouched
        s0 = start_cnt;
        send(M, K'(3), K'(0), 1'b1, errv(K'(0)));
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("reject_cycle1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("reject_cycle2_valid", bus.out_valid, 1);
        drain();
        send({K{1'b1}}, K'(2), K'(0), 1'b1, errv(K'(0)));
        bus.in_valid = 1'b0;
        drain();
        check("reject_no_start", K'(start_cnt - s0), 0);

        // consumer stalls for 20 cycles
        bus.out_ready = 1'b0;
        send(K'(7), K'(3), K'(0), 1'b1, okv(K'(343)));
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 30000) begin
            @(negedge clk);
            n++;
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, K'(343));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_valid_low", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("release_in_ready_next", bus.in_ready, 1);
        drain();

        // reset during exponentiation discards the operation
        send(K'(5), K'(16'hFFFF), K'(0), 1'b0, okv(K'(0)));
        bus.in_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("mid_state_exp_run", bus.dbg_state, 3'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(K'(2), K'(5), K'(0), 1'b1, okv(K'(32)));
        bus.in_valid = 1'b0;
        drain();

`ifdef RSA_DECODER_FAULT_CHECK_EN
        send(K'(3), K'(1), K'(1), 1'b1, okv(K'(3)));
        send(K'(3), K'(2), K'(1), 1'b1, errv(K'(9)));
`else
        send(K'(3), K'(2), K'(1), 1'b1, okv(K'(9)));
`endif
        bus.in_valid = 1'b0;
        drain();

        check("queue_empty", K'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsa_decoder.md
Name: rsa_decoder

Overview:
- RSA decryption front-end for the RSA datapath: accepts a ciphertext word, computes plaintext = c^d mod m and returns it on a valid/ready output.
- Drives one internal mod_exp instance through the level start/done handshake, with the same modulus parameters as the encoder path.
- Rejects out-of-range ciphertexts. Optionally re-encrypts the result to detect faults.

Parameters:
- k, 192, operand/modulus width in bits
- logk, 8, width of bit-index counters inside mod_exp
- m, 192'hfffffffffffffffffffffffffffffffeffffffffffffffff, modulus; passed to mod_exp
- exp_2k, 192'h000000000000000100000000000000020000000000000001, Montgomery constant (2^2k mod m); passed to mod_exp

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ciphertext word offered
- in_ready  out  1  block can accept a word
- in_data  in  k  ciphertext c
- d_key  in  k  private exponent d; sampled on accept
- e_key  in  k  public exponent e; sampled on accept; used only with FAULT_CHECK_EN
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  k  plaintext
- out_err  out  1  result invalid (range or check failure); qualified by out_valid
- busy  out  1  operation in progress (any state other than IDLE)

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk. All registers are on posedge clk.
- Reset values: in_ready=1, out_valid=0, out_err=0, out_data=0, busy=0, FSM=IDLE, mod_exp start=0. The internal mod_exp shares rst_n.
- Input accept: handshake completes when in_valid && in_ready. in_ready=1 only in IDLE. On accept, register c, d and e, then go to RANGE.
- Operand stability: mod_exp operands (x, y) come only from these internal registers and stay stable from start assertion until done.
- IDLE: wait for accept.
- RANGE (1 cycle):
  - c >= m (unsigned, k-bit): out_data=0, out_err=1, go to OUT. No exponentiation.
  - Otherwise go to EXP_RUN.
- EXP_RUN:
  - Drive mod_exp start=1, x=d, y=c.
  - On the first cycle mod_exp done=1, capture z into the result register and go to EXP_REL.
- EXP_REL:
  - Drive start=0 for at least one cycle.
  - mod_exp returns to its IDLE on the next edge. The next start may only be raised after this cycle.
  - Without the feature, go to OUT. With the feature, go to CHK_RUN.
- OUT:
  - out_valid=1. out_data and out_err hold stable until out_ready=1.
  - On out_valid && out_ready go to IDLE. out_valid drops and in_ready rises on the following cycle.
- Latency: accept-to-out_valid = 3 + T_exp cycles, where T_exp is the mod_exp start-to-done time. A range reject has out_valid 2 cycles after accept.
- Back-to-back: no overlap. A new word is accepted only after the previous result is consumed.
- in_valid while busy: ignored (in_ready=0); the producer must hold it.
- Reset mid-operation: FSM returns to IDLE immediately, out_valid drops, and the partial result is discarded. mod_exp is also reset.
- d_key=0: mod_exp result is passed through unmodified; no special-casing in this block.

Optional Feature:
- Macro: RSA_DECODER_FAULT_CHECK_EN.
- Defined:
  - After EXP_REL, state CHK_RUN drives mod_exp with x=e, y=result. On done, capture z as chk.
  - CHK_REL drives start=0 for 1 cycle.
  - CMP (1 cycle): out_err = (chk != c).
  - out_data is always the decrypted result, even on mismatch. Latency grows by T_exp + 3 cycles.
- Not defined: CHK_*/CMP states, the e_key register and the comparator are absent. e_key is unused. out_err reports the range reject only.

Test Plan:
- Reset, then c=3, d=2 -> out_valid with out_data=9, out_err=0; busy high from accept until consumed.
- c=5, d=1 -> out_data=5. Then c=0, d=7 -> out_data=0. Then c=1, d=k'hFFFF -> out_data=1. All back-to-back with in_valid held; in_ready=0 throughout each operation.
- c=m, d=3 -> out_err=1, out_data=0, out_valid exactly 2 cycles after accept; mod_exp start never asserted.
- c=7, d=3, out_ready held low 20 cycles after out_valid -> out_data=343 stable, in_ready=0; one cycle after out_ready=1, out_valid=0; the cycle after that, in_ready=1.
- rst_n pulsed low mid EXP_RUN -> out_valid=0, in_ready=1 immediately. Next c=2, d=5 -> out_data=32, correct.
- With RSA_DECODER_FAULT_CHECK_EN:
  - c=3, d=1, e=1 -> out_data=3, out_err=0.
  - c=3, d=2, e=1 -> out_data=9, out_err=1.
